// File: rtl/line_buffer_scheduler.sv
// Ping-pong line-buffer scheduler: steers decoded camera lines into two RAM banks and
// streams full banks out with SOF/EOL. Macro LINE_SCHED_PATTERN_EN swaps stream data for a pattern.
module line_buffer_scheduler #(
  parameter int LINE_WORDS = 960,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CAM_CLK,
  input  logic                  RESET,
  input  logic                  VSYNC_IN,
  input  logic                  HSYNC_IN,
  input  logic                  LINE_END_IN,
  input  logic                  WR_STB,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic [1:0]            BANK_WE,
  output logic [ADDR_WIDTH-1:0] BANK_WADDR,
  output logic [DATA_WIDTH-1:0] BANK_WDATA,
  output logic                  BANK_RSEL,
  output logic [ADDR_WIDTH-1:0] BANK_RADDR,
  input  logic [DATA_WIDTH-1:0] BANK_RDATA,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic                  M_SOF,
  output logic                  M_EOL,
  output logic [10:0]           LINE_CNT,
  output logic [7:0]            DROP_CNT
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LINE_WORDS - 1);

  typedef enum logic [1:0] {W_IDLE, W_ARM, W_FILL, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

  wstate_t                 wstate_q, wstate_d;
  rstate_t                 rstate_q, rstate_d;
  logic                    vsync_q, line_end_q;
  logic                    vsync_rise, line_end_rise;
  logic                    wbank_q, wbank_d;
  logic                    rbank_q, rbank_d;
  logic [1:0]              full_q, full_d;
  logic [10:0]             line_cnt_q, line_cnt_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic                    pending_sof_q, pending_sof_d;
  logic                    line_sof_q, line_sof_d;
  logic [1:0]              we_q;
  logic [ADDR_WIDTH-1:0]   waddr_q, ridx_q, ridx_d;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    commit, drop, start, clear, xfer, wr_ok;

  assign vsync_rise    = VSYNC_IN & ~vsync_q;
  assign line_end_rise = LINE_END_IN & ~line_end_q;
  assign wr_ok         = (wstate_q == W_FILL) && WR_STB && (WR_ADDR <= LAST_IDX);

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    drop     = 1'b0;
    if (vsync_rise) begin
      wstate_d = W_ARM;
    end else begin
      unique case (wstate_q)
        W_IDLE: wstate_d = W_IDLE;
        W_ARM:  if (HSYNC_IN) wstate_d = full_q[wbank_q] ? W_DROP : W_FILL;
        W_FILL: if (line_end_rise) begin
                  commit   = 1'b1;
                  wstate_d = W_ARM;
                end
        W_DROP: if (line_end_rise) begin
                  drop     = 1'b1;
                  wstate_d = W_ARM;
                end
      endcase
    end
  end

  assign M_VALID = (rstate_q == R_STREAM);
  assign xfer    = M_VALID & M_READY;

  // The read address runs one word ahead only on a transfer, so a stalled RAM keeps
  // re-reading the presented word and its output stays stable without a skid buffer.
  always_comb begin
    rstate_d = rstate_q;
    ridx_d   = ridx_q;
    start    = 1'b0;
    clear    = 1'b0;
    case (rstate_q)
      R_IDLE:   if (full_q[rbank_q]) begin
                  rstate_d = R_FETCH;
                  ridx_d   = '0;
                  start    = 1'b1;
                end
      R_FETCH:  rstate_d = R_STREAM;
      R_STREAM: if (xfer) begin
                  if (ridx_q == LAST_IDX) begin
                    clear    = 1'b1;
                    ridx_d   = '0;
                    rstate_d = R_IDLE;
                  end else begin
                    ridx_d = ridx_q + 1'b1;
                  end
                end
      default:  rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wbank_d    = commit ? ~wbank_q : wbank_q;
    rbank_d    = clear  ? ~rbank_q : rbank_q;
    full_d     = full_q;
    if (commit) full_d[wbank_q] = 1'b1;
    if (clear)  full_d[rbank_q] = 1'b0;
    line_cnt_d = line_cnt_q;
    if (vsync_rise)  line_cnt_d = '0;
    else if (commit) line_cnt_d = line_cnt_q + 11'd1;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    // A frame sync landing on the same cycle as a read start re-arms SOF for the next line.
    pending_sof_d = vsync_rise | (pending_sof_q & ~start);
    line_sof_d    = start ? pending_sof_q : line_sof_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CAM_CLK or posedge RESET) begin
    if (RESET) begin
      wstate_q      <= W_IDLE;
      rstate_q      <= R_IDLE;
      vsync_q       <= 1'b0;
      line_end_q    <= 1'b0;
      wbank_q       <= 1'b0;
      rbank_q       <= 1'b0;
      full_q        <= '0;
      line_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      pending_sof_q <= 1'b0;
      line_sof_q    <= 1'b0;
      we_q          <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      ridx_q        <= '0;
    end else begin
      wstate_q      <= wstate_d;
      rstate_q      <= rstate_d;
      vsync_q       <= VSYNC_IN;
      line_end_q    <= LINE_END_IN;
      wbank_q       <= wbank_d;
      rbank_q       <= rbank_d;
      full_q        <= full_d;
      line_cnt_q    <= line_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      pending_sof_q <= pending_sof_d;
      line_sof_q    <= line_sof_d;
      we_q          <= wr_ok ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;
      ridx_q        <= ridx_d;
      if (wr_ok) begin
        waddr_q <= WR_ADDR;
        wdata_q <= WR_DATA;
      end
    end
  end

  assign BANK_WE    = we_q;
  assign BANK_WADDR = waddr_q;
  assign BANK_WDATA = wdata_q;
  assign BANK_RSEL  = rbank_q;
  assign BANK_RADDR = ridx_d;
  assign M_SOF      = M_VALID && (ridx_q == '0) && line_sof_q;
  assign M_EOL      = M_VALID && (ridx_q == LAST_IDX);
  assign LINE_CNT   = line_cnt_q;
  assign DROP_CNT   = drop_cnt_q;

`ifdef LINE_SCHED_PATTERN_EN
  logic [5:0] tag_q [2];

  always_ff @(posedge CAM_CLK or posedge RESET) begin
    if (RESET) begin
      tag_q[0] <= '0;
      tag_q[1] <= '0;
    end else if (commit) begin
      tag_q[wbank_q] <= line_cnt_d[5:0];
    end
  end

  assign M_DATA = M_VALID ? DATA_WIDTH'({tag_q[rbank_q], ridx_q}) : '0;
`else
  assign M_DATA = M_VALID ? BANK_RDATA : '0;
`endif

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Self-checking bench for line_buffer_scheduler: random line data and stall patterns are
// checked against a line-level model (bank contents, full flags, expected word queue).
module tb_line_buffer_scheduler;

  localparam int LW = 960;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0, hsync = 1'b0, line_end = 1'b0, wr_stb = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  bank_we;
  logic [9:0]  bank_waddr, bank_raddr;
  logic [15:0] bank_wdata, bank_rdata, m_data;
  logic        bank_rsel, m_valid, m_ready = 1'b0, m_sof, m_eol;
  logic [10:0] line_cnt;
  logic [7:0]  drop_cnt;

  line_buffer_scheduler dut (
    .CAM_CLK(clk), .RESET(rst), .VSYNC_IN(vsync), .HSYNC_IN(hsync),
    .LINE_END_IN(line_end), .WR_STB(wr_stb), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .BANK_WE(bank_we), .BANK_WADDR(bank_waddr), .BANK_WDATA(bank_wdata),
    .BANK_RSEL(bank_rsel), .BANK_RADDR(bank_raddr), .BANK_RDATA(bank_rdata),
    .M_DATA(m_data), .M_VALID(m_valid), .M_READY(m_ready), .M_SOF(m_sof),
    .M_EOL(m_eol), .LINE_CNT(line_cnt), .DROP_CNT(drop_cnt)
  );

  always #5 clk = ~clk;

  // Two line-buffer RAM banks with a registered read port.
  logic [15:0] mem [2][1024];
  always @(posedge clk) begin
    if (bank_we[0]) mem[0][bank_waddr] <= bank_wdata;
    if (bank_we[1]) mem[1][bank_waddr] <= bank_wdata;
    bank_rdata <= mem[bank_rsel][bank_raddr];
  end

  // ---------------- line-level reference model ----------------
  typedef enum {LS_WAIT_FRAME, LS_WAIT_LINE, LS_CAPTURE, LS_DISCARD} line_mode_e;
  typedef struct { logic [15:0] d; logic sof; logic eol; logic bank; } exp_t;

  line_mode_e  m_mode;
  logic [15:0] m_bank [2][LW];
  bit          m_full [2];
  bit          m_wbank, m_pending;
  logic [10:0] m_line_cnt;
  int          m_drop;
  int          m_we [2];
  exp_t        exp_q [$];

  int vectors = 0, misc = 0;
  int we_cnt [2];
  int xfer_total = 0, sof_seen = 0, eol_seen = 0, cur_idx = 0;
  logic [15:0] last_eol_data = '0;
  bit rand_mode = 1'b0, fixed_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = LS_WAIT_FRAME;
    m_full[0] = 0; m_full[1] = 0;
    m_wbank = 0; m_pending = 0; m_line_cnt = '0; m_drop = 0;
    exp_q.delete();
  endtask

  task automatic m_vsync();
    m_mode = LS_WAIT_LINE; m_line_cnt = '0; m_pending = 1;
  endtask

  task automatic m_hsync();
    if (m_mode == LS_WAIT_LINE) m_mode = m_full[m_wbank] ? LS_DISCARD : LS_CAPTURE;
  endtask

  task automatic m_write(input int a, input logic [15:0] d);
    if (m_mode == LS_CAPTURE && a < LW) begin
      m_bank[m_wbank][a] = d;
      m_we[m_wbank]++;
    end
  endtask

  task automatic m_line_end();
    exp_t e;
    if (m_mode == LS_CAPTURE) begin
      m_full[m_wbank] = 1;
      m_line_cnt++;
      for (int i = 0; i < LW; i++) begin
`ifdef LINE_SCHED_PATTERN_EN
        e.d = {m_line_cnt[5:0], 10'(i)};
`else
        e.d = m_bank[m_wbank][i];
`endif
        e.sof  = (i == 0) && m_pending;
        e.eol  = (i == LW - 1);
        e.bank = m_wbank;
        exp_q.push_back(e);
      end
      m_pending = 0;
      m_wbank   = ~m_wbank;
      m_mode    = LS_WAIT_LINE;
    end else if (m_mode == LS_DISCARD) begin
      m_drop = (m_drop == 255) ? 255 : m_drop + 1;
      m_mode = LS_WAIT_LINE;
    end
  endtask

  // ---------------- compare and ready processes ----------------
  task automatic monitor_loop();
    exp_t e;
    bit prev_v = 0, prev_r = 0, prev_sof = 0, prev_eol = 0;
    logic [15:0] prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v  = 0;
        cur_idx = 0;
      end else begin
        if (bank_we != 2'b00) begin
          check("we_onehot", 32'($countones(bank_we)), 1);
          if (bank_we[0]) we_cnt[0]++;
          if (bank_we[1]) we_cnt[1]++;
        end
        if (m_valid) begin
          if (prev_v && !prev_r) begin
            check("stall_data", m_data, prev_d);
            check("stall_sof", m_sof, prev_sof);
            check("stall_eol", m_eol, prev_eol);
          end
          if (m_ready) begin
            if (exp_q.size() == 0) begin
              vectors++; misc++;
              $display("FAIL extra_word: got data %0h, expected no word (t=%0t)", m_data, $time);
            end else begin
              e = exp_q.pop_front();
              check("word_data", m_data, e.d);
              check("word_sof", m_sof, e.sof);
              check("word_eol", m_eol, e.eol);
              check("word_bank", bank_rsel, e.bank);
              xfer_total++;
              if (m_sof) sof_seen++;
              if (e.eol) begin
                eol_seen++;
                last_eol_data = m_data;
                m_full[e.bank] = 0;
                cur_idx = 0;
              end else begin
                cur_idx++;
              end
            end
          end
        end
        prev_v = m_valid; prev_r = m_ready; prev_d = m_data;
        prev_sof = m_sof; prev_eol = m_eol;
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge clk); #1;
      m_ready = rand_mode ? ($urandom_range(0, 99) >= 30) : fixed_ready;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_vsync();
    vsync = 1; m_vsync(); tick(); vsync = 0; tick();
  endtask

  task automatic start_line();
    hsync = 1; m_hsync(); tick(); hsync = 0;
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    wr_stb = 1; wr_addr = 10'(a); wr_data = d; m_write(a, d); tick(); wr_stb = 0;
  endtask

  task automatic end_line();
    line_end = 1; m_line_end(); tick(); line_end = 0; tick();
  endtask

  task automatic send_line(input bit rand_data, input bit gaps);
    start_line();
    for (int i = 0; i < LW; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick();
      write_word(i, rand_data ? 16'($urandom) : 16'(i));
    end
    end_line();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 20000) begin tick(); n++; end
    check("drain_in_budget", 32'(n < 20000), 1);
    repeat (4) tick();
  endtask

  task automatic wait_bank_free();
    int n = 0;
    while (m_full[m_wbank] && n < 20000) begin tick(); n++; end
    check("bank_free_in_budget", 32'(n < 20000), 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s_sof, s_eol, s_xfer, w0, w1, n;
    bit b4;
    for (int b = 0; b < 2; b++) for (int i = 0; i < 1024; i++) mem[b][i] = '0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < LW; i++) m_bank[b][i] = '0;
    m_we[0] = 0; m_we[1] = 0; we_cnt[0] = 0; we_cnt[1] = 0;
    m_reset();
    fork
      monitor_loop();
      ready_loop();
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", bank_we, 0);       check("rst_valid", m_valid, 0);
    check("rst_sof", m_sof, 0);        check("rst_eol", m_eol, 0);
    check("rst_data", m_data, 0);      check("rst_line_cnt", line_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0); check("rst_rsel", bank_rsel, 0);
    check("rst_raddr", bank_raddr, 0); check("rst_waddr", bank_waddr, 0);
    check("rst_wdata", bank_wdata, 0);
    tick(); rst = 0; tick();

    // T1: one full line, data = address, ready held high, read-out latency.
    fixed_ready = 1;
    tick();
    do_vsync();
    start_line();
    for (int i = 0; i < LW; i++) write_word(i, 16'(i));
    line_end = 1; m_line_end();
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("latency_not_early", m_valid, 0);
    @(posedge clk); @(negedge clk);
    check("latency_first_valid", m_valid, 1);
    tick(); line_end = 0;
    wait_drain();
    check("t1_words", xfer_total, 960);
    check("t1_sof_count", sof_seen, 1);
    check("t1_eol_count", eol_seen, 1);
`ifndef LINE_SCHED_PATTERN_EN
    check("t1_last_data", last_eol_data, 959);
`endif
    check("t1_line_cnt", line_cnt, 1);
    check("t1_we0", we_cnt[0], 960);
    check("t1_we1", we_cnt[1], 0);

    // T2: three lines with ready low -> third dropped; then drop-counter saturation.
    fixed_ready = 0;
    tick(); tick();
    do_vsync();
    s_sof = sof_seen; s_eol = eol_seen; w0 = we_cnt[0]; w1 = we_cnt[1];
    repeat (3) send_line(1, 0);
    check("t2_drop_cnt", drop_cnt, 1);
    check("t2_line_cnt", line_cnt, 2);
    check("t2_we_total", (we_cnt[0] - w0) + (we_cnt[1] - w1), 1920);
    check("t2_we0_model", we_cnt[0], m_we[0]);
    check("t2_we1_model", we_cnt[1], m_we[1]);
    repeat (260) begin start_line(); end_line(); end
    check("drop_saturated", drop_cnt, 255);
    check("drop_model", drop_cnt, m_drop);
    check("t2_nothing_streamed", eol_seen - s_eol, 0);
    fixed_ready = 1;
    wait_drain();
    check("t2_sof_count", sof_seen - s_sof, 1);
    check("t2_eol_count", eol_seen - s_eol, 2);
    check("t2_line_cnt_after", line_cnt, m_line_cnt);

    // T3: random stalls (30% low) over four lines with gaps between strobes.
    rand_mode = 1;
    do_vsync();
    s_eol = eol_seen; s_xfer = xfer_total;
    for (int l = 0; l < 4; l++) begin
      wait_bank_free();
      send_line(1, 1);
    end
    wait_drain();
    rand_mode = 0;
    check("t3_line_cnt", line_cnt, 4);
    check("t3_eol_count", eol_seen - s_eol, 4);
    check("t3_words", xfer_total - s_xfer, 4 * LW);
    check("t3_drop_unchanged", drop_cnt, m_drop);

    // T4: frame sync after 500 words abandons the partial bank.
    tick();
    do_vsync();
    b4 = m_wbank; w0 = we_cnt[b4]; s_sof = sof_seen; s_eol = eol_seen;
    start_line();
    for (int i = 0; i < 500; i++) write_word(i, 16'($urandom));
    do_vsync();
    check("t4_line_cnt_cleared", line_cnt, 0);
    repeat (20) begin @(negedge clk); check("t4_no_stream", m_valid, 0); end
    tick();
    send_line(1, 0);
    wait_drain();
    check("t4_same_bank_writes", we_cnt[b4] - w0, 1460);
    check("t4_sof_count", sof_seen - s_sof, 1);
    check("t4_eol_count", eol_seen - s_eol, 1);
    check("t4_line_cnt", line_cnt, 1);

    // T5: out-of-range addresses never reach the banks.
    w0 = we_cnt[0]; w1 = we_cnt[1];
    start_line();
    write_word(960, 16'hBEEF);
    write_word(1023, 16'hDEAD);
    tick(); tick();
    check("t5_no_we_oob", (we_cnt[0] - w0) + (we_cnt[1] - w1), 0);
    check("t5_we0_model", we_cnt[0], m_we[0]);
    check("t5_we1_model", we_cnt[1], m_we[1]);
    for (int i = 0; i < LW; i++) write_word(i, 16'($urandom));
    end_line();
    wait_drain();
    check("t5_line_cnt", line_cnt, m_line_cnt);

    // T6: reset in the middle of a read-out.
    do_vsync();
    send_line(1, 0);
    n = 0;
    while (cur_idx < 300 && n < 5000) begin tick(); n++; end
    check("t6_reach_word300", 32'(n < 5000), 1);
    rst = 1; #1;
    check("t6_valid_dropped", m_valid, 0);
    check("t6_line_cnt", line_cnt, 0);
    check("t6_drop_cnt", drop_cnt, 0);
    check("t6_we", bank_we, 0);
    check("t6_rsel", bank_rsel, 0);
    m_reset();
    tick(); tick(); rst = 0; tick();
    repeat (10) begin @(negedge clk); check("t6_no_leftover_stream", m_valid, 0); end
    tick();
    w0 = we_cnt[0]; w1 = we_cnt[1]; s_sof = sof_seen;
    do_vsync();
    send_line(1, 0);
    wait_drain();
    check("t6_bank0_writes", we_cnt[0] - w0, 960);
    check("t6_bank1_writes", we_cnt[1] - w1, 0);
    check("t6_sof_count", sof_seen - s_sof, 1);
    check("t6_line_cnt_after", line_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule

// File: doc/line_buffer_scheduler.md
Name: line_buffer_scheduler

Overview:
Sits directly behind the camera MIPI line decoder, in the CAM_CLK domain. Steers each decoded line of 16-bit words into one of two line-buffer RAM banks (ping-pong) and tracks which banks are full. Reads full banks back out as a valid/ready word stream with start-of-frame and end-of-line flags for the downstream HDMI/frame-buffer path. Lines arriving when no bank is free are dropped and counted.

Parameters:
LINE_WORDS, 960, words per line; read-out always streams exactly this many.
ADDR_WIDTH, 10, bank address width.
DATA_WIDTH, 16, word width.

Ports:
CAM_CLK  in  1  single clock for all logic.
RESET  in  1  asynchronous, active-high reset.
VSYNC_IN  in  1  frame-sync level from decoder.
HSYNC_IN  in  1  line-sync level from decoder.
LINE_END_IN  in  1  line-end level; the line ends on its rising edge.
WR_STB  in  1  word-write strobe from decoder.
WR_ADDR  in  ADDR_WIDTH  word address within the line.
WR_DATA  in  DATA_WIDTH  word data.
BANK_WE  out  2  one-hot write enable, bank 0 and bank 1.
BANK_WADDR  out  ADDR_WIDTH  bank write address.
BANK_WDATA  out  DATA_WIDTH  bank write data.
BANK_RSEL  out  1  bank being read.
BANK_RADDR  out  ADDR_WIDTH  bank read address.
BANK_RDATA  in  DATA_WIDTH  RAM read data, 1-cycle latency.
M_DATA  out  DATA_WIDTH  stream word.
M_VALID  out  1  stream valid.
M_READY  in  1  stream ready.
M_SOF  out  1  marks the first word of a frame.
M_EOL  out  1  marks the last word of a line.
LINE_CNT  out  11  lines committed since the last VSYNC rise.
DROP_CNT  out  8  dropped lines; saturates at 255; cleared only by RESET.

Behaviour:
- Reset values: all outputs 0. Write FSM is W_IDLE. Both full flags are 0. Write bank and read bank are 0.
- Edge detect: VSYNC_IN and LINE_END_IN rising edges use one registered copy of each signal.
- Write FSM:
  - W_IDLE: goes to W_ARM on a VSYNC rise.
  - W_ARM: on HSYNC_IN high, goes to W_FILL if full[wbank]==0, otherwise to W_DROP.
  - W_FILL: each WR_STB with WR_ADDR<LINE_WORDS produces BANK_WE[wbank]=1 one cycle later, with address and data registered. WR_STB with WR_ADDR>=LINE_WORDS is ignored. On a LINE_END rise: set full[wbank], toggle wbank, increment LINE_CNT, go to W_ARM.
  - W_DROP: no writes are issued. On a LINE_END rise: increment DROP_CNT (saturating), go to W_ARM.
- A VSYNC rise in any state clears LINE_CNT, sets the pending-SOF flag and goes to W_ARM. A partially filled bank is abandoned (not marked full) and wbank is unchanged.
- Read FSM:
  - R_IDLE: on full[rbank]==1, go to R_FETCH with raddr=0.
  - R_FETCH: 1-cycle RAM latency, then R_STREAM.
  - R_STREAM: present the words of rbank in order 0..LINE_WORDS-1.
    - A word transfers when M_VALID&&M_READY.
    - While M_READY is low, M_DATA, M_SOF and M_EOL are held stable and M_VALID stays high. A 2-entry skid buffer or read-address hold is required.
    - No word is skipped or duplicated.
  - After word LINE_WORDS-1 transfers: clear full[rbank], toggle rbank, return to R_IDLE.
- Read-out latency: the first M_VALID occurs 2 cycles after full[rbank] sets.
- M_EOL is high with word LINE_WORDS-1. M_SOF is high with word 0 of the first line read after a VSYNC rise; the pending-SOF flag then clears.
- A line shorter than LINE_WORDS still streams LINE_WORDS words; the tail contains stale bank content.
- Simultaneous set of full[wbank] and clear of full[rbank] in one cycle: both take effect. They are always different banks, by construction.
- A VSYNC rise does not abort an in-progress read-out.
- Asserting RESET mid-line or mid-stream immediately returns everything to reset values. No partial stream completes.

Optional Feature:
LINE_SCHED_PATTERN_EN:
- Defined: M_DATA = {LINE_CNT_at_commit[5:0], word_index[9:0]} in place of BANK_RDATA. Bank writes and handshakes are unchanged.
- Undefined: M_DATA carries BANK_RDATA.

Test Plan:
- VSYNC rise, HSYNC, 960 strobes with WR_DATA=addr, LINE_END rise, M_READY=1 -> BANK_WE[0] pulsed 960 times; 960 words 0..959 stream out; M_SOF on word 0; M_EOL on word 959; LINE_CNT=1.
- Three back-to-back lines with M_READY=0 -> lines 1 and 2 fill banks 0 and 1; line 3 is dropped; DROP_CNT=1. Then M_READY=1 -> lines 1 then 2 stream out; M_SOF only on line 1.
- Random M_READY, 30% low, over 4 lines -> every word is delivered exactly once and in order; data is stable while stalled.
- VSYNC rise after 500 words of a line -> that bank is not streamed; LINE_CNT=0; the next full line streams into the same bank with M_SOF=1.
- WR_STB with WR_ADDR=960 and 1023 -> no BANK_WE pulse.
- RESET asserted mid-stream at word 300 -> M_VALID=0 immediately, all counters and full flags 0; the next frame starts cleanly in bank 0.
